// File: rtl/fpu_fpr_sb_pkg.sv
// Shared defaults, port indices and read-bus helper for the FP register file with busy scoreboard.
package fpu_fpr_pkg;

  localparam int FPLEN_DEF     = 32;
  localparam int NREGS_DEF     = 32;
  localparam int AW_DEF        = 5;
  localparam int NRD_DEF       = 3;
  localparam int RADDR_BUS_MAX = 256;

  localparam int RPORT_RS1  = 0;
  localparam int RPORT_RS2  = 1;
  localparam int RPORT_RS3  = 2;
  localparam int WPORT_FPU  = 0;
  localparam int WPORT_LOAD = 1;

  typedef enum logic [1:0] {
    WSRC_NONE = 2'd0,
    WSRC_FPU  = 2'd1,
    WSRC_LOAD = 2'd2
  } wsrc_e;

  typedef logic [RADDR_BUS_MAX-1:0] raddr_bus_t;

  // Extracts read port 'port' from a packed address bus of 'aw'-bit fields.
  function automatic logic [31:0] raddr_at(input raddr_bus_t bus, input int unsigned port,
                                           input int unsigned aw);
    logic [31:0] mask;
    mask = (32'd1 << aw) - 32'd1;
    return 32'(bus >> (port * aw)) & mask;
  endfunction

endpackage

// File: rtl/fpu_fpr_sb_if.sv
// Issue/execute-side bus of the FP register file: reads, two write ports, scoreboard control.
interface fpu_fpr_sb_if
  import fpu_fpr_pkg::*;
#(
  parameter int FPLEN = FPLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = AW_DEF,
  parameter int NRD   = NRD_DEF
) ();

  logic [NRD-1:0]       rden;
  logic [NRD*AW-1:0]    raddr;
  logic [NRD*FPLEN-1:0] rd;
  logic [NRD-1:0]       hazard;

  logic                 wen0;
  logic [AW-1:0]        waddr0;
  logic [FPLEN-1:0]     wd0;
  logic                 wen1;
  logic [AW-1:0]        waddr1;
  logic [FPLEN-1:0]     wd1;
  logic                 wr_collide;

  logic                 issue_v;
  logic [AW-1:0]        issue_rd;
  logic                 flush;
  logic [NREGS-1:0]     busy;

  modport master (
    output rden, raddr, wen0, waddr0, wd0, wen1, waddr1, wd1, issue_v, issue_rd, flush,
    input  rd, hazard, wr_collide, busy
  );

  modport slave (
    input  rden, raddr, wen0, waddr0, wd0, wen1, waddr1, wd1, issue_v, issue_rd, flush,
    output rd, hazard, wr_collide, busy
  );

endinterface

// File: rtl/fpu_fpr_sb_scoreboard.sv
// Per-register busy bits (flush > issue set > wen0 clear) and read-port hazard lookup.
// FPU_FPR_BYPASS_EN: a same-cycle wen0 to the read address suppresses that port's hazard.
module fpu_fpr_scoreboard
  import fpu_fpr_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = AW_DEF,
  parameter int NRD   = NRD_DEF
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              issue_v,
  input  logic [AW-1:0]     issue_rd,
  input  logic              flush,
  input  logic              wen0,
  input  logic [AW-1:0]     waddr0,
  input  logic [NRD-1:0]    rden,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD-1:0]    hazard,
  output logic [NREGS-1:0]  busy
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [AW-1:0]    hz_addr;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NREGS; r++) begin
      if (flush) begin
        busy_d[r] = 1'b0;
      end else if (issue_v && issue_rd == AW'(r)) begin
        busy_d[r] = 1'b1;
      end else if (wen0 && waddr0 == AW'(r)) begin
        busy_d[r] = 1'b0;
      end
    end
  end

  // NOTE: flops use non-blocking <= so all state updates on an edge see pre-edge values.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Out-of-range addresses match no register, so they never flag a hazard.
  always_comb begin
    hazard  = '0;
    hz_addr = '0;
    for (int i = 0; i < NRD; i++) begin
      hz_addr = AW'(raddr_at(raddr_bus_t'(raddr), i, AW));
      for (int r = 0; r < NREGS; r++) begin
        if (hz_addr == AW'(r) && busy_q[r]) begin
          hazard[i] = rden[i];
        end
      end
`ifdef FPU_FPR_BYPASS_EN
      if (wen0 && waddr0 == hz_addr) begin
        hazard[i] = 1'b0;
      end
`endif
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/fpu_fpr_sb.sv
// FP register file: NRD combinational read ports, FPU (wins) and load write ports, busy scoreboard.
// FPU_FPR_BYPASS_EN: reads forward same-cycle write data (wd0 over wd1) instead of stored values.
module fpu_fpr_sb
  import fpu_fpr_pkg::*;
#(
  parameter int FPLEN = FPLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = AW_DEF,
  parameter int NRD   = NRD_DEF
) (
  input  logic           clk,
  input  logic           rst_l,
  input  logic           scan_mode,
  fpu_fpr_sb_if.slave    bus
);

  logic [FPLEN-1:0] mem [NREGS];
  logic [AW-1:0]    rd_addr;
  logic             rd_hit;
  logic [FPLEN-1:0] rd_val;
`ifdef FPU_FPR_BYPASS_EN
  wsrc_e            rd_src;
`endif

  // Scan insertion hooks the flops later; functionally the pin is inert.
  logic unused_scan_mode;
  assign unused_scan_mode = scan_mode;

  // NOTE: the array carries an async clear, so it is built from flops, not a RAM macro.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int r = 0; r < NREGS; r++) begin
        mem[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (bus.wen0 && bus.waddr0 == AW'(r)) begin
          mem[r] <= bus.wd0;
        end else if (bus.wen1 && bus.waddr1 == AW'(r)) begin
          mem[r] <= bus.wd1;
        end
      end
    end
  end

  always_comb begin
    bus.rd  = '0;
    rd_addr = '0;
    rd_hit  = 1'b0;
    rd_val  = '0;
`ifdef FPU_FPR_BYPASS_EN
    rd_src  = WSRC_NONE;
`endif
    for (int i = 0; i < NRD; i++) begin
      rd_addr = AW'(raddr_at(raddr_bus_t'(bus.raddr), i, AW));
      rd_hit  = 1'b0;
      rd_val  = '0;
      for (int r = 0; r < NREGS; r++) begin
        if (rd_addr == AW'(r)) begin
          rd_hit = 1'b1;
          rd_val = mem[r];
        end
      end
`ifdef FPU_FPR_BYPASS_EN
      rd_src = WSRC_NONE;
      if (bus.wen1 && bus.waddr1 == rd_addr) rd_src = WSRC_LOAD;
      if (bus.wen0 && bus.waddr0 == rd_addr) rd_src = WSRC_FPU;
      if (rd_hit) begin
        case (rd_src)
          WSRC_FPU:  rd_val = bus.wd0;
          WSRC_LOAD: rd_val = bus.wd1;
          default:   ;
        endcase
      end
`endif
      if (rst_l && rd_hit && bus.rden[i]) begin
        bus.rd[i*FPLEN +: FPLEN] = rd_val;
      end
    end
  end

  assign bus.wr_collide = rst_l & bus.wen0 & bus.wen1 & (bus.waddr0 == bus.waddr1);

  fpu_fpr_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW),
    .NRD   (NRD)
  ) u_scoreboard (
    .clk      (clk),
    .rst_l    (rst_l),
    .issue_v  (bus.issue_v),
    .issue_rd (bus.issue_rd),
    .flush    (bus.flush),
    .wen0     (bus.wen0),
    .waddr0   (bus.waddr0),
    .rden     (bus.rden),
    .raddr    (bus.raddr),
    .hazard   (bus.hazard),
    .busy     (bus.busy)
  );

endmodule

// File: doc/fpu_fpr_sb.md
# fpu_fpr_sb

Parametrised floating-point register file with two write ports, NRD read ports and a per-register busy scoreboard. It sits between the FPU issue stage and the FPU execute/load-return paths. It supplies operands, flags read-after-write hazards against long-latency ops such as the divider and square root, and accepts results from the FPU pipe and from the load/move path.

## Interface
Parameters:
- FPLEN, 32, register width in bits
- NREGS, 32, number of architectural FP registers (2..32)
- AW, 5, address width; NREGS <= 2**AW
- NRD, 3, number of read ports

Ports:
- clk  in  1  clock
- rst_l  in  1  asynchronous active-low reset
- scan_mode  in  1  passed through to the flops; no functional effect
- rden  in  NRD  per-port read enable
- raddr  in  NRD*AW  packed read addresses; port i is at [i*AW +: AW]
- rd  out  NRD*FPLEN  packed read data; port i is at [i*FPLEN +: FPLEN]
- hazard  out  NRD  port i is reading a busy register
- wen0, waddr0[AW-1:0], wd0[FPLEN-1:0]  in  FPU result write port; clears busy
- wen1, waddr1[AW-1:0], wd1[FPLEN-1:0]  in  load/move write port; does not touch busy
- wr_collide  out  1  wen0 and wen1 target the same address in this cycle
- issue_v, issue_rd[AW-1:0]  in  marks a destination register busy
- flush  in  1  clears all busy bits
- busy  out  NREGS  current scoreboard state

## Operation
- Reset (rst_l low, asynchronous):
  - all registers and busy bits go to 0
  - rd = 0, hazard = 0, wr_collide = 0 while rst_l is low
- Write on the rising clk edge:
  - wen0 writes wd0 to waddr0; wen1 writes wd1 to waddr1
  - If both ports hit the same address, port 0 wins and the port 1 data is dropped. wr_collide = wen0 & wen1 & (waddr0 == waddr1), combinational.
  - A write address >= NREGS is ignored.
- Read (combinational):
  - rd[i] = 0 if rden[i] is low or raddr[i] >= NREGS
  - otherwise rd[i] is the stored value, or the bypassed value when FPU_FPR_BYPASS_EN is defined
- Scoreboard, next-state per register r:
  - flush: busy[r] goes to 0. Flush beats issue in the same cycle; the issue is squashed.
  - else issue_v & issue_rd == r: busy[r] goes to 1. Set beats a same-cycle wen0 clear, because the new op is younger.
  - else wen0 & waddr0 == r: busy[r] goes to 0
  - issue_rd >= NREGS is ignored
- Hazard:
  - hazard[i] = rden[i] & busy[raddr[i]] for in-range addresses
  - With bypass enabled, a same-cycle wen0 to raddr[i] suppresses hazard[i].

## Timing
- Write-to-read latency: 1 cycle with bypass off; 0 cycles (same cycle) with bypass on.
- issue_v to busy/hazard: 1 cycle. Busy clears 1 cycle after wen0.
- No stalls and no backpressure. Every write is accepted in the cycle it is presented.
- Reset may assert mid-operation; it overrides all pending writes, issues and flushes immediately.

## Configuration
- FPU_FPR_BYPASS_EN defined:
  - A read whose address matches a same-cycle write returns that write's data. wd0 has priority over wd1.
  - hazard is suppressed by a matching wen0.
- Undefined:
  - Reads return only stored values.
  - hazard stays asserted until the cycle after wen0.

## Structure
- Package fpu_fpr_pkg holds:
  - the FPLEN/NREGS/AW defaults
  - the port index constants
  - a function that unpacks a read address from the packed bus
- Sub-module fpu_fpr_scoreboard (NREGS, AW) implements the busy bits, their set/clear/flush priority, and the hazard lookup.
- The storage array, write priority, read muxes and bypass stay in the top module.

## Test plan
- Reset, then rden=3'b111, raddr=0/1/31 -> rd all 0x00000000, hazard=0.
- wen0 to f5 = 0x3F800000, read f5 in the next cycle -> 0x3F800000. With bypass on, the same-cycle read also returns 0x3F800000.
- wen0 to f7 = 0x40000000 and wen1 to f7 = 0xC0000000 in the same cycle -> wr_collide=1; f7 reads 0x40000000 afterwards.
- Scoreboard sequence:
  - issue_v with issue_rd=f3 -> busy[3]=1 in the next cycle; reading f3 gives hazard=1
  - wen0 to f3 -> busy[3]=0 in the next cycle
  - issue f3 together with wen0 f3 -> busy[3] stays 1
- Set busy on f1, f2, f9, then flush together with issue_rd=f4 -> busy all 0 in the next cycle.
- Assert rst_l low asynchronously mid-write after f10 = 0x12345678 -> rd=0 immediately; after release f10 reads 0 and busy=0.
